traffic_intersection_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 24 ++
 rtl/ped_request_latch.sv | 29 ++
 rtl/traffic_intersection_scheduler.sv | 126 ++++++++++++
 tb/tb_traffic_intersection_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-way intersection scheduler.
// Phase codes, direction selector and lamp encodings.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALLRED    = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_WALK      = 3'd5,
    PH_EMERG     = 3'd6
  } phase_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/ped_request_latch.sv
// Pedestrian button edge detector with a sticky pending flag.
// Clear wins over a same-tick press so that press rides the current walk.
module ped_request_latch (
  input  logic slow_clock,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic pending
);

  logic btn_q;
  logic pulse;

  assign pulse = btn & ~btn_q;

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      btn_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      btn_q <= btn;
      if (clear)
        pending <= 1'b0;
      else if (pulse)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_intersection_scheduler.sv
// Two-way intersection sequencer with pedestrian walk and emergency hold.
// Lamps decode straight from the registered phase.
module traffic_intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int T_GREEN     = 4,
  parameter int T_MIN_GREEN = 2,
  parameter int T_YELLOW    = 1,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 2,
  parameter int TIMER_W     = 4
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       ped_btn,
  input  logic       emergency,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] G_LAST  = TIMER_W'(T_GREEN - 1);
  localparam logic [TIMER_W-1:0] MG_LAST = TIMER_W'(T_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(T_YELLOW - 1);
  localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(T_ALLRED - 1);
  localparam logic [TIMER_W-1:0] W_LAST  = TIMER_W'(T_WALK - 1);

  phase_t             phase_q, phase_d;
  dir_t               dir_q, dir_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  phase_t             green_sel;
  logic               green_cut;
  logic               walk_clear;

  assign green_sel = (dir_q == DIR_NS) ? PH_NS_GREEN : PH_EW_GREEN;
  assign green_cut = (timer_q == G_LAST) ||
                     (ped_pending && (timer_q >= MG_LAST));
  assign walk_clear = (phase_d == PH_WALK) && (phase_q != PH_WALK);

  ped_request_latch u_ped (
    .slow_clock (slow_clock),
    .reset      (reset),
    .btn        (ped_btn),
    .clear      (walk_clear),
    .pending    (ped_pending)
  );

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    if (emergency && (phase_q != PH_EMERG)) begin
      phase_d = PH_EMERG;
    end else begin
      case (phase_q)
        PH_EMERG: begin
          if (!emergency) begin
            phase_d = PH_ALLRED;
            dir_d   = DIR_NS;
          end
        end
        PH_ALLRED: begin
          if (timer_q == AR_LAST)
            phase_d = ped_pending ? PH_WALK : green_sel;
        end
        PH_WALK: begin
          if (timer_q == W_LAST)
            phase_d = green_sel;
        end
        PH_NS_GREEN: begin
          if (green_cut)
            phase_d = PH_NS_YELLOW;
        end
        PH_EW_GREEN: begin
          if (green_cut)
            phase_d = PH_EW_YELLOW;
        end
        PH_NS_YELLOW, PH_EW_YELLOW: begin
          if (timer_q == Y_LAST) begin
            phase_d = PH_ALLRED;
            dir_d   = (dir_q == DIR_NS) ? DIR_EW : DIR_NS;
          end
        end
        default: phase_d = PH_ALLRED;
      endcase
    end
  end

  // An emergency hold keeps the timer parked at zero.
  always_comb begin
    if ((phase_d != phase_q) || (phase_q == PH_EMERG))
      timer_d = '0;
    else
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_ALLRED;
      dir_q   <= DIR_NS;
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    ns_light = LIGHT_R;
    ew_light = LIGHT_R;
    walk     = 1'b0;
    case (phase_q)
      PH_NS_GREEN:  ns_light = LIGHT_G;
      PH_NS_YELLOW: ns_light = LIGHT_Y;
      PH_EW_GREEN:  ew_light = LIGHT_G;
      PH_EW_YELLOW: ew_light = LIGHT_Y;
      PH_WALK:      walk     = 1'b1;
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_intersection_scheduler.sv
// Directed bench for the intersection scheduler.
// Samples on the falling edge, drives inputs on the falling edge.
module tb_traffic_intersection_scheduler;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       ped_btn = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  traffic_intersection_scheduler dut (
    .slow_clock  (slow_clock),
    .reset       (reset),
    .ped_btn     (ped_btn),
    .emergency   (emergency),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  always #5 slow_clock = ~slow_clock;

  logic [2:0] seq_ph [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                              3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
  logic [2:0] seq_ns [12] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] seq_ew [12] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                              3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

  always @(negedge slow_clock) begin
    if (!reset) begin
      checks++;
      if ((ns_light != 3'b100 && ew_light != 3'b100) ||
          (walk && (ns_light != 3'b100 || ew_light != 3'b100)) ||
          (phase == 3'd7)) begin
        errors++;
        $display("FAIL invariant t=%0t phase=%0d ns=%b ew=%b walk=%b",
                 $time, phase, ns_light, ew_light, walk);
      end
    end
  end

  task automatic step();
    @(negedge slow_clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic expect_ph(string tag, logic [2:0] ph, logic [2:0] ns,
                           logic [2:0] ew, logic wk, logic pend);
    checks++;
    if (phase !== ph || ns_light !== ns || ew_light !== ew ||
        walk !== wk || ped_pending !== pend) begin
      errors++;
      $display("FAIL %s got ph=%0d ns=%b ew=%b walk=%b pend=%b want ph=%0d ns=%b ew=%b walk=%b pend=%b",
               tag, phase, ns_light, ew_light, walk, ped_pending,
               ph, ns, ew, wk, pend);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    expect_ph("reset", 3'd0, 3'b100, 3'b100, 1'b0, 1'b0);
  endtask

  task automatic test_cycle();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i > 0) step();
      expect_ph($sformatf("cycle_%0d", i), seq_ph[i % 12],
                seq_ns[i % 12], seq_ew[i % 12], 1'b0, 1'b0);
    end
  endtask

  task automatic test_ped_walk();
    do_reset();
    step();
    expect_ph("ped_g1", 3'd1, 3'b001, 3'b100, 1'b0, 1'b0);
    ped_btn = 1'b1;
    step();
    expect_ph("ped_g2", 3'd1, 3'b001, 3'b100, 1'b0, 1'b1);
    ped_btn = 1'b0;
    step();
    expect_ph("ped_y", 3'd2, 3'b010, 3'b100, 1'b0, 1'b1);
    step();
    expect_ph("ped_ar", 3'd0, 3'b100, 3'b100, 1'b0, 1'b1);
    step();
    expect_ph("ped_w1", 3'd5, 3'b100, 3'b100, 1'b1, 1'b0);
    step();
    expect_ph("ped_w2", 3'd5, 3'b100, 3'b100, 1'b1, 1'b0);
    step();
    expect_ph("ped_ewg", 3'd3, 3'b100, 3'b001, 1'b0, 1'b0);
  endtask

  task automatic test_ped_held();
    int walks = 0;
    do_reset();
    ped_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step();
      if (i == 10) ped_btn = 1'b0;
      if (walk) walks++;
    end
    checks++;
    if (walks !== 2 || ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL ped_held walk_ticks=%0d pend=%b want 2 and 0",
               walks, ped_pending);
    end
  endtask

  task automatic test_emergency();
    do_reset();
    for (int i = 1; i <= 7; i++) step();
    expect_ph("em_ewg", 3'd3, 3'b100, 3'b001, 1'b0, 1'b0);
    emergency = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_ph($sformatf("em_hold_%0d", i), 3'd6, 3'b100, 3'b100,
                1'b0, 1'b0);
    end
    emergency = 1'b0;
    step();
    expect_ph("em_ar", 3'd0, 3'b100, 3'b100, 1'b0, 1'b0);
    step();
    expect_ph("em_nsg", 3'd1, 3'b001, 3'b100, 1'b0, 1'b0);
  endtask

  task automatic test_emergency_ped();
    do_reset();
    step();
    ped_btn   = 1'b1;
    emergency = 1'b1;
    step();
    ped_btn = 1'b0;
    expect_ph("emp_hold", 3'd6, 3'b100, 3'b100, 1'b0, 1'b1);
    step();
    emergency = 1'b0;
    step();
    expect_ph("emp_ar", 3'd0, 3'b100, 3'b100, 1'b0, 1'b1);
    step();
    expect_ph("emp_walk", 3'd5, 3'b100, 3'b100, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    step();
    ped_btn = 1'b1;
    step();
    ped_btn = 1'b0;
    step();
    expect_ph("mr_y", 3'd2, 3'b010, 3'b100, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    expect_ph("mr_async", 3'd0, 3'b100, 3'b100, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      expect_ph($sformatf("mr_seq_%0d", i), seq_ph[i], seq_ns[i],
                seq_ew[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_ped_walk();
    test_ped_held();
    test_emergency();
    test_emergency_ped();
    test_mid_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
